if_prefetch_unit: RTL and testbench



---
 rtl/if_prefetch_unit.sv | 97 +++++++++
 tb/tb_if_prefetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: fetch stage with instruction memory, sequential loader and prefetch queue
module if_prefetch_unit #(
    parameter int unsigned INST_SZ    = 32,
    parameter int unsigned PC_SZ      = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_run,
    input  logic                           i_load_en,
    input  logic [INST_SZ-1:0]             i_load_data,
    input  logic                           i_pc_src_D,
    input  logic [PC_SZ-1:0]               i_branch_addr_D,
    input  logic                           i_jump_D,
    input  logic [PC_SZ-1:0]               i_jump_addr_D,
    input  logic                           i_jump_sel_D,
    input  logic [PC_SZ-1:0]               i_rs_addr_D,
    input  logic                           i_stall_D,
    output logic                           o_valid_F,
    output logic [INST_SZ-1:0]             o_instruction_F,
    output logic [PC_SZ-1:0]               o_pc_F,
    output logic [PC_SZ-1:0]               o_npc_F,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count,
    output logic [$clog2(MEM_DEPTH)-1:0]   o_load_addr
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FULL = (FW+1)'(FIFO_DEPTH);
    localparam logic [PC_SZ-1:0] STEP = PC_SZ'(PC_STEP);

    logic [INST_SZ-1:0] mem_q [MEM_DEPTH];
    logic [INST_SZ-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [PC_SZ-1:0]   fifo_pc_q [FIFO_DEPTH];
    logic [INST_SZ-1:0] ms_inst_q;
    logic [PC_SZ-1:0]   pc_q, pc_d, ms_pc_q, ms_pc_d, target;
    logic               ms_valid_q, ms_valid_d;
    logic [FW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FW:0]        count_q, count_d;
    logic [AW-1:0]      load_ptr_q, load_ptr_d, mem_idx;
    logic               redirect, issue, push, pop;

    always_comb begin
        redirect   = i_jump_sel_D | i_jump_D | i_pc_src_D;
        target     = i_jump_sel_D ? i_rs_addr_D : i_jump_D ? i_jump_addr_D : i_branch_addr_D;
        // Credit counts the in-flight read so the queue can never overflow.
        issue      = i_run && !redirect && ((count_q + (FW+1)'(ms_valid_q)) < FULL);
        push       = ms_valid_q && !redirect;
        pop        = (count_q != '0) && !i_stall_D && !redirect;
        mem_idx    = AW'(pc_q / STEP);
        pc_d       = redirect ? target : issue ? pc_q + STEP : pc_q;
        ms_valid_d = issue;
        ms_pc_d    = issue ? pc_q : ms_pc_q;
        wr_ptr_d   = redirect ? '0 : wr_ptr_q + FW'(push);
        rd_ptr_d   = redirect ? '0 : rd_ptr_q + FW'(pop);
        count_d    = redirect ? '0 : count_q + (FW+1)'(push) - (FW+1)'(pop);
        load_ptr_d = i_load_en ? load_ptr_q + 1'b1 : load_ptr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q       <= PC_SZ'(RESET_PC);
            ms_valid_q <= 1'b0;
            ms_pc_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            load_ptr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            ms_valid_q <= ms_valid_d;
            ms_pc_q    <= ms_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            load_ptr_q <= load_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && i_load_en) mem_q[load_ptr_q] <= i_load_data;
        if (issue) ms_inst_q <= mem_q[mem_idx];
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= ms_inst_q;
            fifo_pc_q[wr_ptr_q]   <= ms_pc_q;
        end
    end

    assign o_valid_F       = count_q != '0;
    assign o_instruction_F = o_valid_F ? fifo_inst_q[rd_ptr_q] : '0;
    assign o_pc_F          = o_valid_F ? fifo_pc_q[rd_ptr_q] : '0;
    assign o_npc_F         = o_valid_F ? fifo_pc_q[rd_ptr_q] + STEP : '0;
    assign o_fifo_count    = count_q;
    assign o_load_addr     = load_ptr_q;
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed vector table plus hand sequences for loader, wrap and reset
module tb_if_prefetch_unit;
    logic        clk = 1'b0;
    logic        rst, run, load_en, br, jp, js, stall;
    logic [31:0] load_data, br_addr, jp_addr, rs_addr;
    logic        valid;
    logic [31:0] inst, pc, npc;
    logic [2:0]  cnt;
    logic [7:0]  laddr;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        run, stall, br, jp, js;
        logic [31:0] bra, jpa, rsa;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    if_prefetch_unit dut (
        .i_clk(clk), .i_reset(rst), .i_run(run), .i_load_en(load_en), .i_load_data(load_data),
        .i_pc_src_D(br), .i_branch_addr_D(br_addr), .i_jump_D(jp), .i_jump_addr_D(jp_addr),
        .i_jump_sel_D(js), .i_rs_addr_D(rs_addr), .i_stall_D(stall),
        .o_valid_F(valid), .o_instruction_F(inst), .o_pc_F(pc), .o_npc_F(npc),
        .o_fifo_count(cnt), .o_load_addr(laddr)
    );

    function automatic logic [31:0] w(input int i);
        return (i < 4) ? 32'h11 * 32'(i + 1) : 32'hA000_0000 + 32'(i);
    endfunction

    function automatic vec_t v(input logic r, s, b, input logic [31:0] ba, input logic j,
                               input logic [31:0] ja, input logic x, input logic [31:0] xa,
                               input logic ev, input logic [31:0] ep, ei, input logic [2:0] ec);
        vec_t t;
        t.run = r; t.stall = s; t.br = b; t.bra = ba; t.jp = j; t.jpa = ja; t.js = x; t.rsa = xa;
        t.e_valid = ev; t.e_pc = ep; t.e_inst = ei; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_out(input string n, input logic ev, input logic [31:0] ep, ei,
                           input logic [2:0] ec);
        chk({n, ".valid"}, 32'(valid), 32'(ev));
        chk({n, ".pc"}, pc, ep);
        chk({n, ".inst"}, inst, ei);
        chk({n, ".npc"}, npc, ev ? ep + 32'd4 : 32'd0);
        chk({n, ".count"}, 32'(cnt), 32'(ec));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; run = 0; load_en = 0; br = 0; jp = 0; js = 0; stall = 0;
        load_data = 0; br_addr = 0; jp_addr = 0; rs_addr = 0;
        step(); step();
        chk_out("reset", 1'b0, 32'd0, 32'd0, 3'd0);
        chk("reset.laddr", 32'(laddr), 32'd0);
        rst = 0;
        for (int i = 0; i < 256; i++) begin
            load_en = 1; load_data = w(i);
            step();
            if (i < 4) chk($sformatf("load%0d.laddr", i), 32'(laddr), 32'(i + 1));
        end
        load_en = 0;
        chk("load.wrap.laddr", 32'(laddr), 32'd0);
        chk_out("load.idle", 1'b0, 32'd0, 32'd0, 3'd0);

        vecs.push_back(v(1,0,0,0,0,0,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h0,w(0),1));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h4,w(1),1));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h8,w(2),1));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'hC,w(3),1));
        vecs.push_back(v(1,1,0,0,0,0,0,0, 1,32'hC,w(3),2));
        vecs.push_back(v(1,1,0,0,0,0,0,0, 1,32'hC,w(3),3));
        vecs.push_back(v(1,1,0,0,0,0,0,0, 1,32'hC,w(3),4));
        vecs.push_back(v(1,1,0,0,0,0,0,0, 1,32'hC,w(3),4));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h10,w(4),3));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h14,w(5),2));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h18,w(6),2));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h1C,w(7),2));
        vecs.push_back(v(1,1,0,0,0,0,0,0, 1,32'h1C,w(7),3));
        vecs.push_back(v(1,0,1,32'h40,0,0,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h40,w(16),1));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h44,w(17),1));
        vecs.push_back(v(1,0,1,32'h10,1,32'h20,1,32'h30, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h30,w(12),1));
        vecs.push_back(v(0,0,0,0,1,32'h3FC,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 0,32'h0,32'h0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h3FC,w(255),1));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h400,w(0),1));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 1,32'h404,w(1),1));

        foreach (vecs[i]) begin
            run = vecs[i].run; stall = vecs[i].stall;
            br = vecs[i].br; br_addr = vecs[i].bra;
            jp = vecs[i].jp; jp_addr = vecs[i].jpa;
            js = vecs[i].js; rs_addr = vecs[i].rsa;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_cnt);
        end
        br = 0; jp = 0; js = 0; stall = 0;

        // 257th load lands in word 0 while the queue keeps draining
        run = 0; load_en = 1; load_data = 32'hDEAD_BEEF;
        step();
        load_en = 0;
        chk("load257.laddr", 32'(laddr), 32'd1);
        chk_out("load257.q", 1'b1, 32'h408, w(2), 3'd1);

        run = 1; rst = 1;
        step();
        rst = 0;
        chk_out("midreset", 1'b0, 32'd0, 32'd0, 3'd0);
        chk("midreset.laddr", 32'(laddr), 32'd0);
        step();
        chk_out("refetch0", 1'b0, 32'd0, 32'd0, 3'd0);
        step();
        chk_out("refetch1", 1'b1, 32'h0, 32'hDEAD_BEEF, 3'd1);
        step();
        chk_out("refetch2", 1'b1, 32'h4, w(1), 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
